// File: rtl/sum.sv
// Lane summer: combinational exact and wrapped sums of LANES packed
// unsigned lanes, plus a one-cycle registered capture path with overflow.

// Per-lane front end: slice one lane out of the bus and zero-extend it
// to the full result width so the accumulation can never truncate.
module sum_lane #(
  parameter int W  = 16,
  parameter int FW = 20
) (
  input  logic [W-1:0]  i_lane,
  output logic [FW-1:0] o_ext
);
  assign o_ext = {{(FW-W){1'b0}}, i_lane};
endmodule

module sum #(
  parameter int LANES = 16,
  parameter int W     = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [LANES*W-1:0]                bus_in,
  input  logic                              in_valid,
  output logic [W-1:0]                      sum_out,
  output logic [W+$clog2(LANES)-1:0]        sum_full,
  output logic [W-1:0]                      sum_q,
  output logic [W+$clog2(LANES)-1:0]        sum_full_q,
  output logic                              ovf_q,
  output logic                              out_valid
);
  // Full width holds LANES*(2^W-1) exactly; LANES must be at least 2 so
  // there is at least one carry bit above the wrapped result.
  localparam int FW = W + $clog2(LANES);

  logic [LANES-1:0][W-1:0]  w_lane;
  logic [LANES-1:0][FW-1:0] w_ext;
  logic [FW-1:0]            w_sum;
  logic                     w_ovf;

  logic [W-1:0]             r_sum_q;
  logic [FW-1:0]            r_sum_full_q;
  logic                     r_ovf_q;
  logic                     r_out_valid;

  assign w_lane = bus_in;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      sum_lane #(.W(W), .FW(FW)) u_lane (
        .i_lane (w_lane[g]),
        .o_ext  (w_ext[g])
      );
    end
  endgenerate

  // Accumulate all zero-extended lanes; structure left to synthesis.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) w_sum = w_sum + w_ext[i];
  end

  // Any bit above the wrapped width means the exact sum exceeded 2^W-1.
  assign w_ovf    = |w_sum[FW-1:W];
  assign sum_full = w_sum;
  assign sum_out  = w_sum[W-1:0];

  // Capture on in_valid; reset wins over a simultaneous capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum_q      <= '0;
      r_sum_full_q <= '0;
      r_ovf_q      <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum_q      <= w_sum[W-1:0];
        r_sum_full_q <= w_sum;
        r_ovf_q      <= w_ovf;
      end
    end
  end

  assign sum_q      = r_sum_q;
  assign sum_full_q = r_sum_full_q;
  assign ovf_q      = r_ovf_q;
  assign out_valid  = r_out_valid;
endmodule

// File: tb/tb_sum.sv
// Randomised and directed bench for sum, checked against an arithmetic
// reference model of the lane sum and capture register behaviour.
module tb_sum;
  localparam int LANES = 16;
  localparam int W     = 16;
  localparam int BW    = LANES*W;

  logic          clk;
  logic          rst_n;
  logic [BW-1:0] bus_in;
  logic          in_valid;
  logic [15:0]   sum_out;
  logic [19:0]   sum_full;
  logic [15:0]   sum_q;
  logic [19:0]   sum_full_q;
  logic          ovf_q;
  logic          out_valid;

  int n_chk  = 0;
  int n_fail = 0;

  // model state for the registered outputs
  int e_q, e_full, e_ovf, e_vld;

  sum #(.LANES(LANES), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_in     (bus_in),
    .in_valid   (in_valid),
    .sum_out    (sum_out),
    .sum_full   (sum_full),
    .sum_q      (sum_q),
    .sum_full_q (sum_full_q),
    .ovf_q      (ovf_q),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_sum(input logic [BW-1:0] b);
    int s = 0;
    for (int i = 0; i < LANES; i++) s += int'(b[W*i +: W]);
    return s;
  endfunction

  function automatic logic [BW-1:0] all_lanes(input logic [15:0] v);
    logic [BW-1:0] b;
    for (int i = 0; i < LANES; i++) b[W*i +: W] = v;
    return b;
  endfunction

  // Apply inputs mid-cycle, check combinational outputs, clock once,
  // advance the model, then check registered outputs.
  task automatic cyc(input logic rn, input logic v, input logic [BW-1:0] b);
    int s;
    rst_n = rn; in_valid = v; bus_in = b;
    #1;
    s = ref_sum(b);
    chk("sum_full", 32'(sum_full), 32'(s));
    chk("sum_out",  32'(sum_out),  32'(s % 65536));
    @(posedge clk);
    if (!rn) begin
      e_q = 0; e_full = 0; e_ovf = 0; e_vld = 0;
    end else if (v) begin
      e_q = s % 65536; e_full = s; e_ovf = (s > 65535) ? 1 : 0; e_vld = 1;
    end else begin
      e_vld = 0;
    end
    #1;
    chk("sum_q",      32'(sum_q),      32'(e_q));
    chk("sum_full_q", 32'(sum_full_q), 32'(e_full));
    chk("ovf_q",      32'(ovf_q),      32'(e_ovf));
    chk("out_valid",  32'(out_valid),  32'(e_vld));
  endtask

  initial begin
    logic [BW-1:0] b;
    rst_n = 1'b0; in_valid = 1'b0; bus_in = '0;
    #2;

    // reset with capture pending and nonzero bus: reset wins
    b = all_lanes(16'h1234);
    cyc(1'b0, 1'b1, b);
    chk("rst_sum_out", 32'(sum_out), 32'h0000_2340);
    cyc(1'b0, 1'b1, b);
    chk("rst_sum_q", 32'(sum_q), 32'h0);

    // first capture right after reset release
    cyc(1'b1, 1'b1, b);
    chk("post_rst_sum_full_q", 32'(sum_full_q), 32'h1_2340);

    // all zero
    cyc(1'b1, 1'b1, '0);
    chk("zero_ovf", 32'(ovf_q), 32'h0);

    // lane0=2, lane1=3, no capture
    b = '0; b[15:0] = 16'd2; b[31:16] = 16'd3;
    cyc(1'b1, 1'b0, b);
    chk("small_sum_full", 32'(sum_full), 32'h5);
    chk("small_hold_q",   32'(sum_q),    32'h0);

    // all lanes 0x0010
    cyc(1'b1, 1'b1, all_lanes(16'h0010));
    chk("x10_sum_q", 32'(sum_q), 32'h100);
    cyc(1'b1, 1'b0, all_lanes(16'h0010));
    chk("x10_vld_drop", 32'(out_valid), 32'h0);

    // all lanes 0xFFFF
    cyc(1'b1, 1'b1, all_lanes(16'hFFFF));
    chk("max_sum_full_q", 32'(sum_full_q), 32'hF_FFF0);
    chk("max_ovf", 32'(ovf_q), 32'h1);

    // exact 0xFFFF: no overflow
    b = '0; b[15:0] = 16'hFFFF;
    cyc(1'b1, 1'b1, b);
    chk("ffff_ovf", 32'(ovf_q), 32'h0);
    b = '0; b[15:0] = 16'h8000; b[31:16] = 16'h7FFF;
    cyc(1'b1, 1'b1, b);
    chk("ffff_split_ovf", 32'(ovf_q), 32'h0);

    // lane14=lane15=0x8000 -> exactly 0x10000
    b = '0; b[14*W +: W] = 16'h8000; b[15*W +: W] = 16'h8000;
    cyc(1'b1, 1'b1, b);
    chk("wrap_sum_q", 32'(sum_q), 32'h0);
    chk("wrap_ovf",   32'(ovf_q), 32'h1);

    // back-to-back captures with changing bus, then hold
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, all_lanes(16'(k*16'h1111 + 16'h0101)));
    cyc(1'b1, 1'b0, all_lanes(16'hAAAA));
    cyc(1'b1, 1'b0, '0);

    // randomised traffic, including heavy-lane bias and rare resets
    for (int n = 0; n < 400; n++) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < LANES; i++) begin
        case (mode)
          0:       b[W*i +: W] = 16'($urandom);
          1:       b[W*i +: W] = 16'(16'hF000 | 16'($urandom));
          2:       b[W*i +: W] = 16'($urandom_range(0, 300));
          default: b[W*i +: W] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
        endcase
      end
      cyc(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
